// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared states, stall masks and stall priority decode for pipeline_ctrl.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_STATE_RUN,
        PC_STATE_HOLD,
        PC_STATE_FLUSH
    } pc_state_e;

    localparam int STALL_W = 6;
    localparam int WD_W    = 16;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    function automatic logic [STALL_W-1:0] stall_decode(
        input logic r_if,
        input logic r_id,
        input logic r_ex,
        input logic r_mem
    );
        return r_mem ? STALL_MEM : r_ex ? STALL_EX : r_id ? STALL_ID : r_if ? STALL_IF : STALL_NONE;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_bus_watchdog.sv
// bus_watchdog: counts consecutive enabled cycles and pulses timeout at TIMEOUT_CYCLES-1.
module bus_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic timeout
);

    logic [WD_W-1:0] count_q, count_d;

    always_comb begin
        timeout = en && (count_q == WD_W'(TIMEOUT_CYCLES - 1));
        count_d = (en && !timeout) ? count_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage stall merge and exception/ERET flush sequencing for the 5-stage core.
// Define PIPELINE_CTRL_TIMEOUT_EN to enable the MEM bus watchdog (bus_timeout).
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = EXC_VECTOR_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_req_if,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               stall_req_mem,
    input  logic               exc_valid,
    input  logic               exc_is_eret,
    input  logic [31:0]        cp0_epc,
    output logic               exc_ack,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               bus_timeout
);

    pc_state_e   state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        flush_q, flush_d;
    logic [31:0] flush_pc_q, flush_pc_d;
    logic [31:0] tgt;
    logic        wd_en;
    logic        timeout;

    assign wd_en = rst && stall_req_mem && (state_q != PC_STATE_FLUSH);

`ifdef PIPELINE_CTRL_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .timeout(timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = wd_en ^ (^TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    assign bus_timeout = timeout;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;
    assign tgt         = exc_is_eret ? cp0_epc : EXC_VECTOR;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        stall      = STALL_NONE;
        exc_ack    = 1'b0;
        case (state_q)
            PC_STATE_RUN: begin
                stall   = stall_decode(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
                exc_ack = exc_valid;
                if (exc_valid) target_d = tgt;
                // A watchdog timeout overrides the MEM stall and redirects immediately.
                if (exc_valid || timeout) begin
                    flush_d    = !stall_req_mem || timeout;
                    state_d    = flush_d ? PC_STATE_FLUSH : PC_STATE_HOLD;
                    flush_pc_d = flush_d ? (exc_valid ? tgt : EXC_VECTOR) : flush_pc_q;
                end
            end
            PC_STATE_HOLD: begin
                stall = stall_req_mem ? STALL_MEM : STALL_NONE;
                if (!stall_req_mem || timeout) begin
                    state_d    = PC_STATE_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = target_q;
                end
            end
            default: state_d = PC_STATE_RUN;
        endcase
        if (!rst) begin
            stall   = STALL_NONE;
            exc_ack = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PC_STATE_RUN;
            target_q   <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

endmodule
